// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the unified memory port arbiter.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 61
);
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              ifFlush;
  logic              ifGnt;
  logic              ifValid;
  logic [DATA_W-1:0] ifData;

  logic              dReq;
  logic              dWe;
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] dWdata;
  logic              dGnt;
  logic              dValid;
  logic [DATA_W-1:0] dData;

  logic              memEn;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;

  logic [31:0]       statIfGnt;
  logic [31:0]       statDGnt;
  logic [31:0]       statConflict;

  modport slave (
    input  ifReq, ifAddr, ifFlush,
    input  dReq, dWe, dAddr, dWdata,
    input  memRdata,
    output ifGnt, ifValid, ifData,
    output dGnt, dValid, dData,
    output memEn, memWe, memAddr, memWdata,
    output statIfGnt, statDGnt, statConflict
  );

  modport master (
    output ifReq, ifAddr, ifFlush,
    output dReq, dWe, dAddr, dWdata,
    output memRdata,
    input  ifGnt, ifValid, ifData,
    input  dGnt, dValid, dData,
    input  memEn, memWe, memAddr, memWdata,
    input  statIfGnt, statDGnt, statConflict
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the load/store stage.
// Define MEM_PORT_ARB_STATS_EN to build the grant/conflict statistics counters.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int   DATA_W    = 64;
  localparam int   ADDR_W    = 61;
  localparam int   STARVE_W  = 4;
  localparam logic SRC_FETCH = 1'b0;
  localparam logic SRC_LOAD  = 1'b1;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_FETCH,
    SEL_DATA
  } sel_e;

  sel_e                sel;
  logic                ifGnt;
  logic                dGnt;
  logic [STARVE_W-1:0] starve;
  logic                starveMax;
  logic [ADDR_W-1:0]   memAddr;
  logic [DATA_W-1:0]   memWdata;
  logic                rdIssue;
  logic                rdSrc;
  logic                tagVld_p [MEM_LAT];
  logic                tagSrc_p [MEM_LAT];
  logic                rspVld;
  logic                rspSrc;
  logic                ifValid;
  logic                dValid;
  logic [DATA_W-1:0]   ifData;
  logic [DATA_W-1:0]   dData;

  function automatic logic [STARVE_W-1:0] satInc(input logic [STARVE_W-1:0] v);
    return (v == STARVE_W'(STARVE_MAX)) ? v : v + STARVE_W'(1);
  endfunction

  // A fetch tag does not survive an edge on which a redirect flush is seen.
  function automatic logic tagSurvives(input logic vld, input logic src, input logic flush);
    return vld && !(flush && (src == SRC_FETCH));
  endfunction

  assign starveMax = (starve == STARVE_W'(STARVE_MAX));

  always_comb begin
    sel = SEL_NONE;
    if (!reset) begin
      if (bus.ifReq && (!bus.dReq || starveMax)) sel = SEL_FETCH;
      else if (bus.dReq)                          sel = SEL_DATA;
    end
  end

  assign ifGnt = (sel == SEL_FETCH);
  assign dGnt  = (sel == SEL_DATA);

  always_comb begin
    memAddr  = '0;
    memWdata = '0;
    case (sel)
      SEL_FETCH: memAddr = bus.ifAddr;
      SEL_DATA: begin
        memAddr = bus.dAddr;
        if (bus.dWe) memWdata = bus.dWdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                       starve <= '0;
    else if (bus.ifReq && !ifGnt)    starve <= satInc(starve);
    else                             starve <= '0;
  end

  // Issue -> tag stage 0; stores never enter the tag pipeline.
  assign rdIssue = (ifGnt && !bus.ifFlush) || (dGnt && !bus.dWe);
  assign rdSrc   = dGnt ? SRC_LOAD : SRC_FETCH;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_LAT; i++) tagVld_p[i] <= 1'b0;
    end else begin
      tagVld_p[0] <= rdIssue;
      for (int i = 1; i < MEM_LAT; i++)
        tagVld_p[i] <= tagSurvives(tagVld_p[i-1], tagSrc_p[i-1], bus.ifFlush);
    end
  end

  always_ff @(posedge clk) begin
    tagSrc_p[0] <= rdSrc;
    for (int i = 1; i < MEM_LAT; i++) tagSrc_p[i] <= tagSrc_p[i-1];
  end

  // Final tag stage -> response registers, memRdata captured on this edge.
  assign rspVld = tagSurvives(tagVld_p[MEM_LAT-1], tagSrc_p[MEM_LAT-1], bus.ifFlush);
  assign rspSrc = tagSrc_p[MEM_LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      ifValid <= 1'b0;
      dValid  <= 1'b0;
      ifData  <= '0;
      dData   <= '0;
    end else begin
      ifValid <= rspVld && (rspSrc == SRC_FETCH);
      dValid  <= rspVld && (rspSrc == SRC_LOAD);
      if (rspVld && (rspSrc == SRC_FETCH)) ifData <= bus.memRdata;
      if (rspVld && (rspSrc == SRC_LOAD))  dData  <= bus.memRdata;
    end
  end

  assign bus.ifGnt    = ifGnt;
  assign bus.dGnt     = dGnt;
  assign bus.memEn    = ifGnt || dGnt;
  assign bus.memWe    = dGnt && bus.dWe;
  assign bus.memAddr  = memAddr;
  assign bus.memWdata = memWdata;
  assign bus.ifValid  = ifValid;
  assign bus.dValid   = dValid;
  assign bus.ifData   = ifData;
  assign bus.dData    = dData;

`ifdef MEM_PORT_ARB_STATS_EN
  logic [31:0] statIfGnt;
  logic [31:0] statDGnt;
  logic [31:0] statConflict;

  always_ff @(posedge clk) begin
    if (reset) begin
      statIfGnt    <= '0;
      statDGnt     <= '0;
      statConflict <= '0;
    end else begin
      if (ifGnt)                  statIfGnt    <= statIfGnt + 32'd1;
      if (dGnt)                   statDGnt     <= statDGnt + 32'd1;
      if (bus.ifReq && bus.dReq)  statConflict <= statConflict + 32'd1;
    end
  end

  assign bus.statIfGnt    = statIfGnt;
  assign bus.statDGnt     = statDGnt;
  assign bus.statConflict = statConflict;
`else
  assign bus.statIfGnt    = '0;
  assign bus.statDGnt     = '0;
  assign bus.statConflict = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) share one stimulus
// stream and are compared every cycle against a queue-based response model.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int NI         = 2;
`ifdef MEM_PORT_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct {
    int          inst;
    int          due;
    bit          src;
    logic [63:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifReq, ifFlush, dReq, dWe;
  logic [60:0] ifAddr, dAddr;
  logic [63:0] dWdata;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if busA ();
  mem_port_arbiter_if busB ();

  assign busA.ifReq = ifReq;  assign busA.ifAddr = ifAddr;  assign busA.ifFlush = ifFlush;
  assign busA.dReq  = dReq;   assign busA.dWe    = dWe;     assign busA.dAddr   = dAddr;
  assign busA.dWdata = dWdata;
  assign busB.ifReq = ifReq;  assign busB.ifAddr = ifAddr;  assign busB.ifFlush = ifFlush;
  assign busB.dReq  = dReq;   assign busB.dWe    = dWe;     assign busB.dAddr   = dAddr;
  assign busB.dWdata = dWdata;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) dutA (.clk(clk), .reset(reset), .bus(busA));
  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(STARVE_MAX)) dutB (.clk(clk), .reset(reset), .bus(busB));

  function automatic logic [63:0] initVal(input logic [60:0] a);
    return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
  endfunction

  // Memory models: write on a store issue, read data appears MEM_LAT cycles after issue.
  logic [63:0] memA [1024];
  bit          wrA  [1024];
  logic [63:0] rdA;
  logic [63:0] memB [1024];
  bit          wrB  [1024];
  logic [63:0] rdB  [3];

  always @(posedge clk) begin
    if (busA.memEn && busA.memWe) begin
      memA[busA.memAddr[9:0]] <= busA.memWdata;
      wrA[busA.memAddr[9:0]]  <= 1'b1;
    end
    if (busA.memEn && !busA.memWe)
      rdA <= wrA[busA.memAddr[9:0]] ? memA[busA.memAddr[9:0]] : initVal(busA.memAddr);
    else
      rdA <= {$urandom, $urandom};
  end
  assign busA.memRdata = rdA;

  always @(posedge clk) begin
    if (busB.memEn && busB.memWe) begin
      memB[busB.memAddr[9:0]] <= busB.memWdata;
      wrB[busB.memAddr[9:0]]  <= 1'b1;
    end
    if (busB.memEn && !busB.memWe)
      rdB[0] <= wrB[busB.memAddr[9:0]] ? memB[busB.memAddr[9:0]] : initVal(busB.memAddr);
    else
      rdB[0] <= {$urandom, $urandom};
    rdB[1] <= rdB[0];
    rdB[2] <= rdB[1];
  end
  assign busB.memRdata = rdB[2];

  // Reference model state
  logic [63:0] refMem [1024];
  bit          refWr  [1024];
  resp_t       pend [$];
  int          mStarve = 0;
  logic        eIfGnt, eDGnt, eMemEn, eMemWe;
  logic [60:0] eMemAddr;
  logic [63:0] eMemWdata;
  logic        eIfValid [NI];
  logic        eDValid  [NI];
  logic [63:0] eIfData  [NI];
  logic [63:0] eDData   [NI];
  logic [31:0] cntIf, cntD, cntC;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] refRead(input logic [60:0] a);
    return refWr[a[9:0]] ? refMem[a[9:0]] : initVal(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic computeGrant();
    eIfGnt    = !reset && ifReq && (!dReq || (mStarve == STARVE_MAX));
    eDGnt     = !reset && dReq && !eIfGnt;
    eMemEn    = eIfGnt || eDGnt;
    eMemWe    = eDGnt && dWe;
    eMemAddr  = eIfGnt ? ifAddr : (eDGnt ? dAddr : 61'd0);
    eMemWdata = eMemWe ? dWdata : 64'd0;
  endtask

  task automatic checkOne(input int k, input logic ifGnt, input logic dGnt, input logic memEn,
                          input logic memWe, input logic [60:0] memAddr, input logic [63:0] memWdata,
                          input logic ifValid, input logic [63:0] ifData, input logic dValid,
                          input logic [63:0] dData, input logic [31:0] sI, input logic [31:0] sD,
                          input logic [31:0] sC);
    string p;
    p = (k == 0) ? "L1" : "L3";
    chk({p, ".ifGnt"},    64'(ifGnt),    64'(eIfGnt));
    chk({p, ".dGnt"},     64'(dGnt),     64'(eDGnt));
    chk({p, ".bothGnt"},  64'(ifGnt && dGnt), 64'(0));
    chk({p, ".memEn"},    64'(memEn),    64'(eMemEn));
    chk({p, ".memWe"},    64'(memWe),    64'(eMemWe));
    if (eMemEn || reset) chk({p, ".memAddr"}, 64'(memAddr), 64'(eMemAddr));
    chk({p, ".memWdata"}, memWdata,      eMemWdata);
    chk({p, ".ifValid"},  64'(ifValid),  64'(eIfValid[k]));
    chk({p, ".ifData"},   ifData,        eIfData[k]);
    chk({p, ".dValid"},   64'(dValid),   64'(eDValid[k]));
    chk({p, ".dData"},    dData,         eDData[k]);
    chk({p, ".statIfGnt"},    64'(sI), 64'(STATS_ON ? cntIf : 32'd0));
    chk({p, ".statDGnt"},     64'(sD), 64'(STATS_ON ? cntD  : 32'd0));
    chk({p, ".statConflict"}, 64'(sC), 64'(STATS_ON ? cntC  : 32'd0));
  endtask

  task automatic updateModel();
    resp_t keep [$];
    if (reset) begin
      pend.delete();
      for (int k = 0; k < NI; k++) begin
        eIfValid[k] = 1'b0; eDValid[k] = 1'b0; eIfData[k] = '0; eDData[k] = '0;
      end
      mStarve = 0;
      cntIf = '0; cntD = '0; cntC = '0;
    end else begin
      for (int k = 0; k < NI; k++) begin
        eIfValid[k] = 1'b0; eDValid[k] = 1'b0;
      end
      foreach (pend[i]) begin
        if (ifFlush && !pend[i].src) continue;
        if (pend[i].due == cyc + 1) begin
          if (pend[i].src) begin
            eDValid[pend[i].inst] = 1'b1; eDData[pend[i].inst] = pend[i].data;
          end else begin
            eIfValid[pend[i].inst] = 1'b1; eIfData[pend[i].inst] = pend[i].data;
          end
        end else begin
          keep.push_back(pend[i]);
        end
      end
      pend = keep;
      for (int k = 0; k < NI; k++) begin
        if (eIfGnt && !ifFlush) pend.push_back('{k, cyc + lat(k) + 1, 1'b0, refRead(ifAddr)});
        if (eDGnt && !dWe)      pend.push_back('{k, cyc + lat(k) + 1, 1'b1, refRead(dAddr)});
      end
      if (eDGnt && dWe) begin
        refMem[dAddr[9:0]] = dWdata;
        refWr[dAddr[9:0]]  = 1'b1;
      end
      if (ifReq && !eIfGnt) mStarve = (mStarve < STARVE_MAX) ? mStarve + 1 : mStarve;
      else                  mStarve = 0;
      if (eIfGnt)        cntIf = cntIf + 32'd1;
      if (eDGnt)         cntD  = cntD + 32'd1;
      if (ifReq && dReq) cntC  = cntC + 32'd1;
    end
  endtask

  task automatic cycle();
    computeGrant();
    @(negedge clk);
    checkOne(0, busA.ifGnt, busA.dGnt, busA.memEn, busA.memWe, busA.memAddr, busA.memWdata,
             busA.ifValid, busA.ifData, busA.dValid, busA.dData,
             busA.statIfGnt, busA.statDGnt, busA.statConflict);
    checkOne(1, busB.ifGnt, busB.dGnt, busB.memEn, busB.memWe, busB.memAddr, busB.memWdata,
             busB.ifValid, busB.ifData, busB.dValid, busB.dData,
             busB.statIfGnt, busB.statDGnt, busB.statConflict);
    updateModel();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    ifReq = 1'b0; dReq = 1'b0; ifFlush = 1'b0; dWe = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      eIfValid[k] = 1'b0; eDValid[k] = 1'b0; eIfData[k] = '0; eDData[k] = '0;
    end
    cntIf = '0; cntD = '0; cntC = '0;
    reset = 1'b1;
    ifReq = 1'b0; ifAddr = '0; ifFlush = 1'b0;
    dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    chk("rst.memEn",   64'(busA.memEn),   64'(0));
    chk("rst.ifValid", 64'(busA.ifValid), 64'(0));
    chk("rst.dValid",  64'(busB.dValid),  64'(0));
    chk("rst.ifData",  busA.ifData,       64'd0);
    chk("rst.dData",   busB.dData,        64'd0);

    // Single fetch, MEM_LAT=1: same-cycle grant, data two cycles later
    reset = 1'b0;
    ifReq = 1'b1; ifAddr = 61'h10;
    #1;
    chk("t1.ifGnt",   64'(busA.ifGnt),   64'(1));
    chk("t1.memAddr", 64'(busA.memAddr), 64'h10);
    chk("t1.memWe",   64'(busA.memWe),   64'(0));
    cycle();
    ifReq = 1'b0;
    cycle();
    chk("t1.ifValid", 64'(busA.ifValid), 64'(1));
    chk("t1.ifData",  busA.ifData,       initVal(61'h10));
    idle(3);

    // Store then load to the same address
    dReq = 1'b1; dWe = 1'b1; dAddr = 61'h20; dWdata = 64'hDEADBEEF_00000001;
    #1;
    chk("t2.stGnt",    64'(busA.dGnt),    64'(1));
    chk("t2.stWdata",  busA.memWdata,     64'hDEADBEEF_00000001);
    cycle();
    dWe = 1'b0;
    #1;
    chk("t2.ldGnt",    64'(busA.dGnt),    64'(1));
    chk("t2.ldWdata",  busA.memWdata,     64'd0);
    cycle();
    dReq = 1'b0;
    chk("t2.noStResp", 64'(busA.dValid),  64'(0));
    cycle();
    chk("t2.dValid",   64'(busA.dValid),  64'(1));
    chk("t2.dData",    busA.dData,        64'hDEADBEEF_00000001);
    idle(4);

    // Continuous conflict: four data grants then one forced fetch grant
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    ifReq = 1'b1; ifAddr = 61'h100; dReq = 1'b1; dWe = 1'b0; dAddr = 61'h200;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3.ifGnt", 64'(busA.ifGnt), 64'((i % 5) == 4));
      chk("t3.dGnt",  64'(busA.dGnt),  64'((i % 5) != 4));
      cycle();
    end
    ifReq = 1'b0; dReq = 1'b0;
    chk("t3.statConflict", 64'(busA.statConflict), STATS_ON ? 64'd10 : 64'd0);
    chk("t3.statDGnt",     64'(busA.statDGnt),     STATS_ON ? 64'd8  : 64'd0);
    chk("t3.statIfGnt",    64'(busA.statIfGnt),    STATS_ON ? 64'd2  : 64'd0);
    idle(5);

    // MEM_LAT=3: fetch at t, load at t+1, flush at t+2
    ifReq = 1'b1; ifAddr = 61'h30;
    cycle();
    ifReq = 1'b0; dReq = 1'b1; dWe = 1'b0; dAddr = 61'h40;
    cycle();
    dReq = 1'b0; ifFlush = 1'b1;
    cycle();
    ifFlush = 1'b0;
    for (int j = 3; j <= 6; j++) begin
      chk("t4.ifValid", 64'(busB.ifValid), 64'(0));
      chk("t4.dValid",  64'(busB.dValid),  64'(j == 5));
      if (j == 5) chk("t4.dData", busB.dData, initVal(61'h40));
      cycle();
    end
    idle(2);

    // Reset one cycle after a load grant
    dReq = 1'b1; dWe = 1'b0; dAddr = 61'h50;
    cycle();
    reset = 1'b1; ifReq = 1'b1; ifAddr = 61'h70; dAddr = 61'h60;
    #1;
    chk("t5.memEnA", 64'(busA.memEn), 64'(0));
    chk("t5.memEnB", 64'(busB.memEn), 64'(0));
    chk("t5.dGnt",   64'(busA.dGnt),  64'(0));
    cycle();
    cycle();
    reset = 1'b0; ifReq = 1'b0; dReq = 1'b0;
    chk("t5.dDataA",  busA.dData,  64'd0);
    chk("t5.ifDataA", busA.ifData, 64'd0);
    chk("t5.dDataB",  busB.dData,  64'd0);
    for (int j = 0; j < 5; j++) begin
      chk("t5.dValidA", 64'(busA.dValid), 64'(0));
      chk("t5.dValidB", 64'(busB.dValid), 64'(0));
      cycle();
    end

    // Randomized traffic with flushes and occasional resets
    for (int n = 0; n < 600; n++) begin
      if (eIfGnt || !ifReq) begin
        ifReq  = ($urandom_range(0, 3) != 0);
        ifAddr = 61'($urandom_range(0, 15));
      end
      if (eDGnt || !dReq) begin
        dReq   = ($urandom_range(0, 2) != 0);
        dWe    = ($urandom_range(0, 1) != 0);
        dAddr  = 61'($urandom_range(0, 15));
        dWdata = {$urandom, $urandom};
      end
      ifFlush = ($urandom_range(0, 9) == 0);
      reset   = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
